// File: rtl/coh_data_fifo.sv
// Coherent-data FIFO: rounds, shifts and saturates correlator I/Q, packs each result with
// its coherent-buffer address and flags, and queues it for the coherent sum arbiter.
module coh_data_fifo #(
  parameter int DEPTH = 8,
  parameter int IN_W  = 24
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  logic                   cor_valid,
  output logic                   cor_ready,
  input  logic [2:0]             cor_index,
  input  logic signed [IN_W-1:0] cor_i,
  input  logic signed [IN_W-1:0] cor_q,
  input  logic [6:0]             chan_base,
  input  logic                   first_coh,
  input  logic                   ow_protect,
  input  logic [2:0]             scale_shift,
  input  logic                   fifo_clear,
  input  logic                   fifo_rd,
  output logic                   fifo_empty,
  output logic [43:0]            fifo_data,
  output logic                   overflow,
  output logic                   saturated,
  input  logic                   flag_clr
);

  localparam int AW    = $clog2(DEPTH);
  localparam int EXT_W = IN_W + 1;
  localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'(32767);
  localparam logic signed [EXT_W-1:0] SAT_MIN = -EXT_W'(32768);

  typedef logic [AW:0] cnt_t;

  logic [43:0]   mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  cnt_t          count;
  logic          s1_valid;
  logic [43:0]   s1_data;

  logic          accept, drop, do_write, do_read;
  logic [16:0]   i_res, q_res;

  // Returns {clipped, value}: round half up, arithmetic shift, clamp to 16-bit signed.
  function automatic logic [16:0] round_sat(input logic signed [IN_W-1:0] x,
                                            input logic [2:0] s);
    logic signed [EXT_W-1:0] ext, sum, r;
    ext = {x[IN_W-1], x};
    sum = ext;
    if (s != 3'd0) sum = ext + (EXT_W'(1) << (s - 3'd1));
    r = sum >>> s;
    if (r > SAT_MAX)      return {1'b1, 16'h7FFF};
    else if (r < SAT_MIN) return {1'b1, 16'h8000};
    else                  return {1'b0, r[15:0]};
  endfunction

  assign i_res = round_sat(cor_i, scale_shift);
  assign q_res = round_sat(cor_q, scale_shift);

  // Ready depends only on registered state, never on cor_valid.
  assign cor_ready  = (count + cnt_t'(s1_valid)) < cnt_t'(DEPTH);
  assign fifo_empty = (count == '0);

  assign accept   = cor_valid && cor_ready && !fifo_clear;
  assign drop     = cor_valid && !cor_ready && !fifo_clear;
  assign do_write = s1_valid && !fifo_clear;
  assign do_read  = fifo_rd && !fifo_empty && !fifo_clear;

  // NOTE: all sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would make results depend on process order.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      fifo_data <= '0;
    end else if (fifo_clear) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      s1_valid  <= 1'b0;
      fifo_data <= '0;
    end else begin
      s1_valid <= accept;
      if (accept)
        s1_data <= {chan_base, cor_index, ow_protect, first_coh, i_res[15:0], q_res[15:0]};
      if (do_write) wptr <= wptr + AW'(1);
      if (do_read) begin
        rptr      <= rptr + AW'(1);
        fifo_data <= mem[rptr];
      end
      count <= count + cnt_t'(do_write) - cnt_t'(do_read);
    end
  end

  // NOTE: storage array is deliberately not reset; pointers and count define validity,
  // and leaving it unreset lets it map onto RAM/register-file cells.
  always_ff @(posedge clk) begin
    if (do_write) mem[wptr] <= s1_data;
  end

  // Sticky flags: a same-cycle set takes priority over flag_clr; fifo_clear leaves them alone.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      overflow  <= 1'b0;
      saturated <= 1'b0;
    end else begin
      if (drop)          overflow <= 1'b1;
      else if (flag_clr) overflow <= 1'b0;

      if (accept && (i_res[16] || q_res[16])) saturated <= 1'b1;
      else if (flag_clr)                      saturated <= 1'b0;
    end
  end

endmodule

// File: tb/tb_coh_data_fifo.sv
// Scoreboard bench for coh_data_fifo: directed pushes enqueue hand-computed entries,
// a monitor compares every pop against the queue.
module tb_coh_data_fifo;

  logic               clk = 1'b0;
  logic               rst_b;
  logic               cor_valid, cor_ready;
  logic [2:0]         cor_index;
  logic signed [23:0] cor_i, cor_q;
  logic [6:0]         chan_base;
  logic               first_coh, ow_protect;
  logic [2:0]         scale_shift;
  logic               fifo_clear, fifo_rd, fifo_empty;
  logic [43:0]        fifo_data;
  logic               overflow, saturated, flag_clr;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [43:0] exp_q[$];
  logic [43:0] last_exp = '0;

  coh_data_fifo #(.DEPTH(8), .IN_W(24)) dut (
    .clk(clk), .rst_b(rst_b), .cor_valid(cor_valid), .cor_ready(cor_ready),
    .cor_index(cor_index), .cor_i(cor_i), .cor_q(cor_q), .chan_base(chan_base),
    .first_coh(first_coh), .ow_protect(ow_protect), .scale_shift(scale_shift),
    .fifo_clear(fifo_clear), .fifo_rd(fifo_rd), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .overflow(overflow), .saturated(saturated), .flag_clr(flag_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [43:0] act, input logic [43:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: a real pop presents its data from the popping edge.
  always @(posedge clk) begin
    if (rst_b && fifo_rd && !fifo_empty && !fifo_clear) begin
      #1;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL pop_unexpected: got %h, expected no entry", fifo_data);
      end else begin
        last_exp = exp_q.pop_front();
        check("pop_data", fifo_data, last_exp);
      end
    end
  end

  task automatic send(input logic [23:0] i, input logic [23:0] q, input logic [2:0] s,
                      input logic [2:0] idx, input logic [6:0] base, input logic fc,
                      input logic op, input logic [15:0] ei, input logic [15:0] eq,
                      input bit acc);
    cor_valid = 1'b1; cor_i = i; cor_q = q; scale_shift = s; cor_index = idx;
    chan_base = base; first_coh = fc; ow_protect = op;
    if (acc) exp_q.push_back({base, idx, op, fc, ei, eq});
    @(negedge clk);
    cor_valid = 1'b0;
  endtask

  task automatic pop();
    fifo_rd = 1'b1;
    @(negedge clk);
    fifo_rd = 1'b0;
  endtask

  task automatic pulse_flag_clr();
    flag_clr = 1'b1;
    @(negedge clk);
    flag_clr = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_empty"},     44'(fifo_empty), 44'd1);
    check({tag, "_ready"},     44'(cor_ready),  44'd1);
    check({tag, "_data"},      fifo_data,       44'd0);
    check({tag, "_overflow"},  44'(overflow),   44'd0);
    check({tag, "_saturated"}, 44'(saturated),  44'd0);
  endtask

  initial begin
    rst_b = 1'b0; cor_valid = 1'b0; cor_index = '0; cor_i = '0; cor_q = '0;
    chan_base = '0; first_coh = 1'b0; ow_protect = 1'b0; scale_shift = '0;
    fifo_clear = 1'b0; fifo_rd = 1'b0; flag_clr = 1'b0;
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    check_reset_outputs("reset");

    // Basic pack: address {5,0} = 0x028, Q = -0x100 -> 0xFF00.
    send(24'h001234, -24'sh000100, 3'd0, 3'd0, 7'd5, 1'b1, 1'b0, 16'h1234, 16'hFF00, 1'b1);
    check("basic_empty_stage1", 44'(fifo_empty), 44'd1);
    @(negedge clk);
    check("basic_empty_written", 44'(fifo_empty), 44'd0);
    check("basic_expected_word", {10'h028, 1'b0, 1'b1, 16'h1234, 16'hFF00}, exp_q[0]);
    pop();
    check("basic_empty_after_pop", 44'(fifo_empty), 44'd1);

    // Rounding and saturation.
    send(24'd7,        24'd0, 3'd1, 3'd1, 7'd2, 1'b0, 1'b1, 16'd4,    16'd0, 1'b1);
    check("sat_after_7", 44'(saturated), 44'd0);
    send(-24'sd7,      24'd0, 3'd1, 3'd2, 7'd2, 1'b0, 1'b0, 16'hFFFD, 16'd0, 1'b1);
    check("sat_after_m7", 44'(saturated), 44'd0);
    send(24'h7FFFFF,   24'd0, 3'd2, 3'd3, 7'd2, 1'b1, 1'b1, 16'h7FFF, 16'd0, 1'b1);
    check("sat_pos_clip", 44'(saturated), 44'd1);
    pulse_flag_clr();
    check("sat_cleared_1", 44'(saturated), 44'd0);
    send(-24'sh800000, 24'd0, 3'd7, 3'd4, 7'd2, 1'b0, 1'b0, 16'h8000, 16'd0, 1'b1);
    check("sat_neg_clip", 44'(saturated), 44'd1);
    pulse_flag_clr();
    check("sat_cleared_2", 44'(saturated), 44'd0);
    repeat (4) pop();
    check("round_drained", 44'(fifo_empty), 44'd1);

    // Fill: eight accepts, then two drops.
    for (int k = 1; k <= 10; k++) begin
      check("fill_ready", 44'(cor_ready), 44'(k <= 8));
      send(24'(k), 24'(k + 16), 3'd0, 3'(k), 7'd9, 1'b0, 1'b0, 16'(k), 16'(k + 16), k <= 8);
    end
    check("fill_overflow", 44'(overflow), 44'd1);
    check("fill_ready_full", 44'(cor_ready), 44'd0);
    for (int k = 0; k < 8; k++) pop();
    check("fill_empty", 44'(fifo_empty), 44'd1);
    pulse_flag_clr();
    check("overflow_cleared", 44'(overflow), 44'd0);

    // Concurrent push/pop across pointer wrap with three entries held.
    for (int k = 0; k < 3; k++)
      send(24'(50 + k), 24'd0, 3'd0, 3'd0, 7'd1, 1'b0, 1'b0, 16'(50 + k), 16'd0, 1'b1);
    @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      fifo_rd = 1'b1;
      send(24'(100 + k), 24'd0, 3'd0, 3'(k), 7'd1, 1'b1, 1'b0, 16'(100 + k), 16'd0, 1'b1);
      check("conc_not_empty", 44'(fifo_empty), 44'd0);
      check("conc_ready", 44'(cor_ready), 44'd1);
    end
    fifo_rd = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) pop();
    check("conc_drained", 44'(fifo_empty), 44'd1);

    // Read while empty: data holds, then normal operation resumes.
    pop();
    check("empty_rd_data", fifo_data, last_exp);
    check("empty_rd_empty", 44'(fifo_empty), 44'd1);
    send(24'h000ABC, 24'h000DEF, 3'd0, 3'd5, 7'd3, 1'b1, 1'b1, 16'h0ABC, 16'h0DEF, 1'b1);
    @(negedge clk);
    pop();
    check("empty_rd_resume", 44'(fifo_empty), 44'd1);

    // Clear with simultaneous valid and read.
    for (int k = 0; k < 4; k++)
      send(24'(200 + k), 24'd0, 3'd0, 3'd0, 7'd4, 1'b0, 1'b0, 16'(200 + k), 16'd0, 1'b1);
    fifo_clear = 1'b1;
    fifo_rd    = 1'b1;
    send(24'd999, 24'd0, 3'd0, 3'd0, 7'd4, 1'b0, 1'b0, 16'd999, 16'd0, 1'b0);
    fifo_clear = 1'b0;
    fifo_rd    = 1'b0;
    exp_q.delete();
    check_reset_outputs("clear");

    // Reset mid-stream with a saturation flag pending.
    send(24'h7FFFFF, 24'd0, 3'd0, 3'd0, 7'd6, 1'b0, 1'b0, 16'h7FFF, 16'd0, 1'b1);
    send(24'd5,      24'd0, 3'd0, 3'd1, 7'd6, 1'b0, 1'b0, 16'd5,    16'd0, 1'b1);
    check("pre_reset_saturated", 44'(saturated), 44'd1);
    rst_b = 1'b0;
    send(24'd6, 24'd0, 3'd0, 3'd2, 7'd6, 1'b0, 1'b0, 16'd6, 16'd0, 1'b0);
    rst_b = 1'b1;
    exp_q.delete();
    check_reset_outputs("midreset");
    @(negedge clk);
    check("midreset_still_empty", 44'(fifo_empty), 44'd1);

    check("scoreboard_left", 44'(exp_q.size()), 44'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/coh_data_fifo.md
# coh_data_fifo

Per-channel coherent-data FIFO that sits directly upstream of the coherent sum stage. Accepts raw correlator I/Q results, applies a rounding right-shift and 16-bit saturation, and packs each result with its coherent-buffer address and control flags into a 44-bit entry. The coherent sum arbiter pops the stored entries. Four instances feed the four coherent FIFO ports of the tracking engine.

## Interface
- DEPTH, 8: FIFO entries. Power of two, minimum 4.
- IN_W, 24: width of the signed correlator I/Q input.

- clk  in  1  system clock.
- rst_b  in  1  reset; one clock, synchronous, active-low.
- cor_valid  in  1  correlator result valid.
- cor_ready  out  1  block can accept cor_valid this cycle.
- cor_index  in  3  correlator index within the channel (0 = prompt/cor0).
- cor_i, cor_q  in  IN_W  signed correlator I and Q.
- chan_base  in  7  channel coherent-buffer base (buffer address bits [9:3]).
- first_coh  in  1  first coherent data of the integration.
- ow_protect  in  1  overwrite-protect indicator.
- scale_shift  in  3  right shift 0..7 applied to I/Q.
- fifo_clear  in  1  synchronous flush.
- fifo_rd  in  1  pop request from the coherent sum stage.
- fifo_empty  out  1  no stored entry.
- fifo_data  out  44  registered head data: [43:34] address, [33] ow_protect, [32] first_coh, [31:16] I, [15:0] Q.
- overflow  out  1  sticky; a result was dropped.
- saturated  out  1  sticky; an I or Q value was clipped.
- flag_clr  in  1  clears overflow and saturated.

## Operation
- **Stage 1 (input register).** Loaded when cor_valid && cor_ready && !fifo_clear. It captures:
  - address {chan_base, cor_index};
  - the two flag bits;
  - the rounded, shifted I and Q.
- **Rounding.** For s = scale_shift: r = (x + (s ? 2^(s-1) : 0)) >>> s. The computation uses IN_W+1 bits (arithmetic shift, round half up).
- **Saturation.** r is clamped to [-32768, 32767]. Any clamp on I or Q sets saturated at the same edge stage 1 loads.
- **Stage 2 (FIFO write).** A valid stage 1 writes the packed entry at the write pointer on the next edge, with wptr+1 and count+1. Stage-1 valid clears unless it is reloaded.
- **Ready.** cor_ready = (count + stage1_valid) < DEPTH. It is driven combinationally from registers only, so it is never dependent on cor_valid.
- **Dropped input.** cor_valid while !cor_ready drops the result and sets overflow. No FIFO state changes.
- **Read.**
  - fifo_rd && !fifo_empty: fifo_data loads mem[rptr], rptr+1, count-1.
  - fifo_rd while empty is ignored; fifo_data holds.
  - fifo_data holds between reads.
- **Simultaneous write and read.** Both take effect and count is unchanged. With count==0, the written entry is not readable in the same cycle; fifo_rd is ignored.
- **Pointers.** Wrap modulo DEPTH.
- **fifo_empty** = (count == 0).
- **fifo_clear** has priority over everything except reset:
  - wptr, rptr, count and stage1_valid go to 0;
  - fifo_data goes to 0;
  - a same-cycle cor_valid is dropped without setting overflow;
  - a same-cycle fifo_rd is ignored;
  - sticky flags are unaffected.
- **flag_clr.** Clears both flags. A same-cycle set wins.
- **Reset.** All state goes to 0:
  - fifo_empty=1, cor_ready=1, fifo_data=0, overflow=0, saturated=0;
  - stage-1 and FIFO contents are discarded;
  - reset mid-transfer loses in-flight data.

## Timing
- cor_valid accepted at edge N: entry written at edge N+1; fifo_empty low during cycle N+1 (after edge N+1).
- A pop at edge M makes fifo_data valid from edge M. This matches the consumer latching data the cycle after its read strobe.
- Throughput is one input per cycle while not full. Reads are one per cycle.
- cor_ready drops the cycle after the accept that makes count+stage1_valid reach DEPTH.
- Sticky flags update on the edge of the causing event.

## Test plan
- **Basic pack.** cor_i=0x001234, cor_q=-0x000100, s=0, chan_base=5, cor_index=0, first_coh=1, ow_protect=0, then pop.
  - Required: fifo_data = {10'h028, 1'b0, 1'b1, 16'h1234, 16'hFF00}, valid the cycle after fifo_rd; fifo_empty returns to 1.
- **Rounding/saturation.**
  - I=7, s=1 → I field 4.
  - I=-7, s=1 → -3.
  - I=0x7FFFFF, s=2 → 0x7FFF and saturated=1.
  - I=-0x800000, s=7 → I field 0x8000 (-32768; -65536 clamped) and saturated=1.
  - flag_clr → saturated=0.
- **Fill/overflow.** DEPTH=8. Push 10 consecutive results with no reads.
  - Required: cor_ready=0 after the 8th accept; results 9–10 dropped; overflow=1.
  - Then 8 pops return entries 1–8 in order; fifo_empty=1 after the 8th pop.
- **Concurrent.** With count=3, push and pop every cycle for 20 cycles.
  - Required: count stays 3; output order matches input order across pointer wrap.
- **Clear/reset.** Push 4 results, then assert fifo_clear with cor_valid and fifo_rd in the same cycle.
  - Required: fifo_empty=1 next cycle; fifo_data=0; overflow stays 0.
  - Repeat with rst_b low mid-stream: all outputs are at their reset values after the edge.
- **Empty read.** Issue fifo_rd on an empty FIFO.
  - Required: fifo_data unchanged; no pointer movement; the next push/pop works normally.
